mem_arbiter: RTL and testbench

//   Shares the single external memory bus between two requesters: port 0 (CPU request path) and port 1
//   (peripheral DMA, e.g. display/keyboard engine). Round-robin grant, one outstanding transaction, held

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one external memory bus between two requesters: port 0 (CPU path)
//   and port 1 (peripheral DMA). The arbiter keeps one transaction outstanding
//   at a time and uses round-robin arbitration. A granted transaction is held
//   until busAck arrives or until the timeout expires.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   read0/write0/address0/data0  port 0 request (write wins if both strobes high)
//   ack0                       port 0 completion, 1-cycle pulse
//   read1/write1/address1/data1  port 1 request
//   ack1                       port 1 completion, 1-cycle pulse
//   dataOut                    read data for the acked port, valid with ack0/ack1
//   error                      pulses with ack0/ack1 when the transfer timed out
//   busRead/busWrite           memory bus strobes (registered)
//   busAddress/busData         memory bus address / write data (registered)
//   busAck, busDataIn          memory bus completion and read data
//   grant                      one-hot owner: 01 port 0, 10 port 1, 00 idle
//
// Handshake: a requester holds readN/writeN until it sees ackN. A request is
// taken in the IDLE cycle in which it is seen. Once it is granted, the requester
// inputs are ignored until the ack. In the cycle that ackN is high, port N's
// request is not looked at, so a requester that drops on ack is not granted twice.
module mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read0,
  input  logic        write0,
  input  logic [31:0] address0,
  input  logic [31:0] data0,
  output logic        ack0,
  input  logic        read1,
  input  logic        write1,
  input  logic [31:0] address1,
  input  logic [31:0] data1,
  output logic        ack1,
  output logic [31:0] dataOut,
  output logic        error,
  output logic        busRead,
  output logic        busWrite,
  output logic [31:0] busAddress,
  output logic [31:0] busData,
  input  logic        busAck,
  input  logic [31:0] busDataIn,
  output logic [1:0]  grant
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;       // index of the port granted most recently
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic req0, req1, pick, pick_wr, tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rdata_d = '0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    req0 = (read0 | write0) & ~ack0_q;
    req1 = (read1 | write1) & ~ack1_q;
    // When both ports request, the port that did not win last time gets the grant.
    pick    = (req0 & req1) ? ~last_q : req1;
    pick_wr = pick ? write1 : write0;
    // busAck is checked before tmo, so busAck in the timeout cycle completes normally.
    tmo     = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = BUSY;
          grant_d = pick ? 2'b10 : 2'b01;
          wr_d    = pick_wr;
          rd_d    = ~pick_wr;
          addr_d  = pick ? address1 : address0;
          wdata_d = pick ? data1 : data0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (busAck || tmo) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = grant_q[1];
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          ack0_d  = grant_q[0];
          ack1_d  = grant_q[1];
          rdata_d = (busAck && !wr_q) ? busDataIn : 32'h0;
          err_d   = ~busAck;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign dataOut    = rdata_q;
  assign error      = err_q;
  assign busRead    = rd_q;
  assign busWrite   = wr_q;
  assign busAddress = addr_q;
  assign busData    = wdata_q;
  assign grant      = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        read0, write0, read1, write1;
  logic [31:0] address0, data0, address1, data1;
  logic        ack0, ack1, error;
  logic [31:0] dataOut;
  logic        busRead, busWrite;
  logic [31:0] busAddress, busData;
  logic        busAck;
  logic [31:0] busDataIn;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;
  int ack_cnt  = 0;

  logic [31:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(4), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .read0(read0), .write0(write0), .address0(address0), .data0(data0), .ack0(ack0),
    .read1(read1), .write1(write1), .address1(address1), .data1(data1), .ack1(ack1),
    .dataOut(dataOut), .error(error),
    .busRead(busRead), .busWrite(busWrite), .busAddress(busAddress), .busData(busData),
    .busAck(busAck), .busDataIn(busDataIn), .grant(grant)
  );

  // Invariants watched on the inactive edge.
  always @(negedge clk) begin
    if ((ack0 && ack1) || (grant == 2'b11)) viol++;
    if (ack0 || ack1) ack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    read0 = 0; write0 = 0; address0 = 0; data0 = 0;
    read1 = 0; write1 = 0; address1 = 0; data1 = 0;
    busAck = 0; busDataIn = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  int got_acks;
  int snap;

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();

    // reset state
    check("rst_busRead", {31'b0, busRead}, 0);
    check("rst_busWrite", {31'b0, busWrite}, 0);
    check("rst_grant", {30'b0, grant}, 0);
    check("rst_acks", {30'b0, ack1, ack0}, 0);
    check("rst_dataOut", dataOut, 0);

    // 1: port 0 read, busAck two cycles after busRead rises
    read0 = 1; address0 = 32'h0000_1000;
    tick();
    check("t1_c1_busRead", {31'b0, busRead}, 1);
    check("t1_c1_grant", {30'b0, grant}, 2'b01);
    check("t1_c1_addr", busAddress, 32'h0000_1000);
    tick();
    check("t1_c2_busRead", {31'b0, busRead}, 1);
    tick();
    check("t1_c3_busRead", {31'b0, busRead}, 1);
    busAck = 1; busDataIn = 32'hCAFE_F00D;
    tick();
    busAck = 0; busDataIn = 0; read0 = 0;
    check("t1_c4_busRead", {31'b0, busRead}, 0);
    check("t1_c4_ack0", {31'b0, ack0}, 1);
    check("t1_c4_dataOut", dataOut, 32'hCAFE_F00D);
    check("t1_c4_error", {31'b0, error}, 0);
    check("t1_c4_grant", {30'b0, grant}, 0);
    tick();
    check("t1_c5_ack0", {31'b0, ack0}, 0);

    // 2: contention straight after reset, bus acks in the strobe cycle
    do_reset();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    read0 = 1; address0 = 32'h0000_2000;
    write1 = 1; address1 = 32'h0000_3000; data1 = 32'h1234_5678;
    got_acks = 0;
    for (int i = 0; i < 20 && got_acks < 4; i++) begin
      tick();
      if (ack0 || ack1) begin
        got_acks++;
        if (exp_q.size() > 0) check("t2_order", {31'b0, ack1}, exp_q.pop_front());
        if (got_acks == 4) begin read0 = 0; write1 = 0; end
      end
      if (busWrite) begin
        check("t2_wdata", busData, 32'h1234_5678);
        check("t2_wgrant", {30'b0, grant}, 2'b10);
      end
      busAck = busRead | busWrite;
    end
    busAck = 0;
    check("t2_acks", got_acks, 4);
    tick();

    // 3: port 1 write, requester drops and changes address mid-transfer
    write1 = 1; address1 = 32'h0000_4000; data1 = 32'h0000_A5A5;
    tick();
    check("t3_c1_grant", {30'b0, grant}, 2'b10);
    write1 = 0; address1 = 32'h0000_9999;
    tick();
    check("t3_c2_addr", busAddress, 32'h0000_4000);
    check("t3_c2_busWrite", {31'b0, busWrite}, 1);
    tick();
    busAck = 1;
    tick();
    busAck = 0;
    check("t3_ack1", {31'b0, ack1}, 1);
    check("t3_error", {31'b0, error}, 0);
    tick();

    // 4: timeout with no busAck (TIMEOUT=4)
    read0 = 1; address0 = 32'h0000_5000; busDataIn = 32'hDEAD_BEEF;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("t4_c%0d_busRead", i), {31'b0, busRead}, 1);
    end
    tick();
    read0 = 0;
    check("t4_busRead", {31'b0, busRead}, 0);
    check("t4_ack0", {31'b0, ack0}, 1);
    check("t4_error", {31'b0, error}, 1);
    check("t4_dataOut", dataOut, 0);
    tick();

    // 5: busAck on the timeout cycle completes normally
    read0 = 1; address0 = 32'h0000_6000;
    tick(); tick(); tick(); tick();
    busAck = 1; busDataIn = 32'hBEEF_0001;
    tick();
    busAck = 0; read0 = 0;
    check("t5_ack0", {31'b0, ack0}, 1);
    check("t5_error", {31'b0, error}, 0);
    check("t5_dataOut", dataOut, 32'hBEEF_0001);
    tick();

    // 6: reset during BUSY aborts with no ack
    snap = ack_cnt;
    read1 = 1; address1 = 32'h0000_7000;
    tick();
    check("t6_c1_busRead", {31'b0, busRead}, 1);
    rst = 1;
    tick();
    rst = 0; read1 = 0;
    check("t6_busRead", {31'b0, busRead}, 0);
    check("t6_grant", {30'b0, grant}, 0);
    busAck = 1; busDataIn = 32'h5555_5555;
    tick();
    busAck = 0;
    for (int i = 0; i < 6; i++) tick();
    check("t6_no_ack", ack_cnt - snap, 0);
    check("t6_dataOut", dataOut, 0);

    check("invariants", viol, 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
